// File: rtl/fir_frame_sequencer.sv
// Frame sequencer for a bit-serial distributed-arithmetic FIR: counts samples into a
// ping-pong buffer, launches one DA pass per frame and holds the result until accepted.
module fir_frame_sequencer #(
   parameter int TAPS       = 128,
   parameter int DATA_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          sample_valid,
   input  logic                          result_ready,
   input  logic                          overrun_clr,
   output logic                          buffer_select,
   output logic                          start_computation,
   output logic                          da_clear,
   output logic                          da_shift_en,
   output logic [$clog2(DATA_WIDTH)-1:0] da_bit_idx,
   output logic                          da_last,
   output logic                          result_valid,
   output logic                          busy,
   output logic                          overrun,
   output logic [15:0]                   frame_count
);

   localparam int CW = $clog2(TAPS);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(TAPS - 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LAUNCH  = 2'd1,
      S_COMPUTE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            pending_q, pending_d;
   logic            overrun_q, overrun_d;
   logic            buffer_select_q, buffer_select_d;
   logic [15:0]     frame_count_q, frame_count_d;

   logic            frame_done;
   logic            result_taken;
   logic            launch_go;
   logic            drop_frame;

   assign frame_done   = sample_valid && enable && (sample_cnt_q == SAMPLE_LAST);
   assign result_taken = (state_q == S_DONE) && result_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (frame_done) begin
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (bit_cnt_q == BIT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (result_ready) begin
               state_d = (pending_q || frame_done) ? S_LAUNCH : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: every output is decoded from registered state only
   always_comb begin
      start_computation = (state_q == S_LAUNCH);
      da_clear          = (state_q == S_LAUNCH);
      da_shift_en       = (state_q == S_COMPUTE);
      da_bit_idx        = (state_q == S_COMPUTE) ? bit_cnt_q : '0;
      da_last           = (state_q == S_COMPUTE) && (bit_cnt_q == BIT_LAST);
      result_valid      = (state_q == S_DONE);
      busy              = (state_q != S_IDLE);
      overrun           = overrun_q;
      buffer_select     = buffer_select_q;
      frame_count       = frame_count_q;
   end

   assign launch_go = (state_d == S_LAUNCH);

   // Counters and launch bookkeeping
   always_comb begin
      sample_cnt_d    = sample_cnt_q;
      bit_cnt_d       = '0;
      buffer_select_d = buffer_select_q;
      frame_count_d   = frame_count_q;

      if (!enable) begin
         sample_cnt_d = '0;
      end else if (sample_valid) begin
         sample_cnt_d = (sample_cnt_q == SAMPLE_LAST) ? '0 : sample_cnt_q + 1'b1;
      end

      if ((state_q == S_COMPUTE) && (bit_cnt_q != BIT_LAST)) begin
         bit_cnt_d = bit_cnt_q + 1'b1;
      end

      if (launch_go) begin
         buffer_select_d = ~buffer_select_q;
         frame_count_d   = frame_count_q + 16'd1;
      end
   end

   // One-deep frame queue. When a queued frame is launched from DONE, a frame
   // finishing in that same cycle takes its place rather than being lost.
   always_comb begin
      pending_d  = pending_q;
      drop_frame = 1'b0;

      if (result_taken) begin
         pending_d = pending_q && frame_done;
      end else if (frame_done && (state_q != S_IDLE)) begin
         if (pending_q) begin
            drop_frame = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      if (!enable) begin
         pending_d = 1'b0;
      end

      if (drop_frame) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt_q    <= '0;
         bit_cnt_q       <= '0;
         pending_q       <= 1'b0;
         overrun_q       <= 1'b0;
         buffer_select_q <= 1'b0;
         frame_count_q   <= '0;
      end else begin
         sample_cnt_q    <= sample_cnt_d;
         bit_cnt_q       <= bit_cnt_d;
         pending_q       <= pending_d;
         overrun_q       <= overrun_d;
         buffer_select_q <= buffer_select_d;
         frame_count_q   <= frame_count_d;
      end
   end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Scoreboard bench for fir_frame_sequencer: directed frames push expected launches and
// result edges into queues; a negedge monitor pops and compares them as the DUT shows them.
module tb_fir_frame_sequencer;

   localparam int DW = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       sample_valid = 1'b0;
   logic       result_ready = 1'b0;
   logic       overrun_clr = 1'b0;
   logic       buffer_select;
   logic       start_computation;
   logic       da_clear;
   logic       da_shift_en;
   logic [3:0] da_bit_idx;
   logic       da_last;
   logic       result_valid;
   logic       busy;
   logic       overrun;
   logic [15:0] frame_count;

   fir_frame_sequencer #(.TAPS(128), .DATA_WIDTH(DW)) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .sample_valid      (sample_valid),
      .result_ready      (result_ready),
      .overrun_clr       (overrun_clr),
      .buffer_select     (buffer_select),
      .start_computation (start_computation),
      .da_clear          (da_clear),
      .da_shift_en       (da_shift_en),
      .da_bit_idx        (da_bit_idx),
      .da_last           (da_last),
      .result_valid      (result_valid),
      .busy              (busy),
      .overrun           (overrun),
      .frame_count       (frame_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int   cyc;
      logic bsel;
      int   fcnt;
   } launch_t;

   launch_t lq[$];
   int      rq[$];
   int      total = 0;
   int      bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   int   exp_bit = 0;
   logic prev_start = 1'b0;
   logic prev_rv = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_start = 1'b0;
         prev_rv    = 1'b0;
      end else begin
         if (start_computation) begin
            chk("start_not_back_to_back", int'(prev_start), 0);
            chk("da_clear_with_start", int'(da_clear), 1);
            if (lq.size() == 0) begin
               total = total + 1;
               bad   = bad + 1;
               $display("FAIL unexpected_launch: got launch at cycle %0d expected none", cyc);
            end else begin
               launch_t e;
               e = lq.pop_front();
               chk("launch_cycle", cyc, e.cyc);
               chk("launch_buffer_select", int'(buffer_select), int'(e.bsel));
               chk("launch_frame_count", int'(frame_count), e.fcnt);
            end
            exp_bit = 0;
         end
         if (da_shift_en) begin
            chk("da_bit_idx", int'(da_bit_idx), exp_bit);
            chk("da_last", int'(da_last), (exp_bit == DW - 1) ? 1 : 0);
            exp_bit = exp_bit + 1;
         end
         if (result_valid && !prev_rv) begin
            if (rq.size() == 0) begin
               total = total + 1;
               bad   = bad + 1;
               $display("FAIL unexpected_result: got result_valid at cycle %0d expected none", cyc);
            end else begin
               chk("result_cycle", cyc, rq.pop_front());
            end
         end
         prev_start = start_computation;
         prev_rv    = result_valid;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input int n, input bit rr_last, output int last);
      last = cyc;
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1;
         if (rr_last && i == n - 1) result_ready = 1'b1;
         last = cyc;
         @(negedge clk);
      end
      sample_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_buffer_select"}, int'(buffer_select), 0);
      chk({tag, "_start"}, int'(start_computation), 0);
      chk({tag, "_da_clear"}, int'(da_clear), 0);
      chk({tag, "_da_shift_en"}, int'(da_shift_en), 0);
      chk({tag, "_da_bit_idx"}, int'(da_bit_idx), 0);
      chk({tag, "_da_last"}, int'(da_last), 0);
      chk({tag, "_result_valid"}, int'(result_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
      chk({tag, "_frame_count"}, int'(frame_count), 0);
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_queues_empty"}, lq.size() + rq.size(), 0);
   endtask

   initial begin
      int c0;
      int last;
      launch_t e;

      // Reset values
      step(1);
      #1;
      chk_reset_outputs("reset");
      do_reset();

      // Single frame, ready held high
      enable = 1'b1;
      result_ready = 1'b1;
      c0 = cyc;
      e.cyc = c0 + 128; e.bsel = 1'b1; e.fcnt = 1;
      lq.push_back(e);
      rq.push_back(c0 + 145);
      send(128, 1'b0, last);
      step(25);
      chk("single_frame_count", int'(frame_count), 1);
      chk("single_buffer_select", int'(buffer_select), 1);
      chk("single_busy_after", int'(busy), 0);
      chk_drained("single");

      // Ten back-to-back frames
      do_reset();
      c0 = cyc;
      for (int k = 1; k <= 10; k++) begin
         e.cyc = c0 + 128 * k; e.bsel = k[0]; e.fcnt = k;
         lq.push_back(e);
         rq.push_back(c0 + 128 * k + 17);
      end
      send(1280, 1'b0, last);
      step(25);
      chk("stream_frame_count", int'(frame_count), 10);
      chk("stream_buffer_select", int'(buffer_select), 0);
      chk("stream_overrun", int'(overrun), 0);
      chk_drained("stream");

      // Stalled consumer: frame 2 queued, frame 3 dropped
      do_reset();
      result_ready = 1'b0;
      c0 = cyc;
      e.cyc = c0 + 128; e.bsel = 1'b1; e.fcnt = 1;
      lq.push_back(e);
      rq.push_back(c0 + 145);
      send(384, 1'b0, last);
      step(2);
      chk("stall_overrun_set", int'(overrun), 1);
      chk("stall_result_held", int'(result_valid), 1);
      chk("stall_frame_count", int'(frame_count), 1);
      c0 = cyc;
      e.cyc = c0 + 1; e.bsel = 1'b0; e.fcnt = 2;
      lq.push_back(e);
      rq.push_back(c0 + 18);
      result_ready = 1'b1;
      step(25);
      chk("stall_frame_count_after", int'(frame_count), 2);
      chk("stall_overrun_sticky", int'(overrun), 1);
      chk("stall_busy_after", int'(busy), 0);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      chk("stall_overrun_cleared", int'(overrun), 0);
      chk_drained("stall");

      // Frame completes in the same cycle the held result is accepted
      do_reset();
      result_ready = 1'b0;
      c0 = cyc;
      e.cyc = c0 + 128; e.bsel = 1'b1; e.fcnt = 1;
      lq.push_back(e);
      e.cyc = c0 + 256; e.bsel = 1'b0; e.fcnt = 2;
      lq.push_back(e);
      rq.push_back(c0 + 145);
      rq.push_back(c0 + 273);
      send(256, 1'b1, last);
      step(40);
      chk("coincide_busy_after", int'(busy), 0);
      chk("coincide_frame_count", int'(frame_count), 2);
      chk_drained("coincide");

      // Reset in the middle of the bit-serial pass
      do_reset();
      result_ready = 1'b1;
      c0 = cyc;
      e.cyc = c0 + 128; e.bsel = 1'b1; e.fcnt = 1;
      lq.push_back(e);
      send(128, 1'b0, last);
      while (cyc < last + 9) step(1);
      chk("midreset_bit_idx_before", int'(da_bit_idx), 7);
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      step(1);
      rst = 1'b0;
      step(1);
      c0 = cyc;
      e.cyc = c0 + 128; e.bsel = 1'b1; e.fcnt = 1;
      lq.push_back(e);
      rq.push_back(c0 + 145);
      send(128, 1'b0, last);
      step(25);
      chk("midreset_frame_count", int'(frame_count), 1);
      chk_drained("midreset");

      // Enable dropped mid-frame restarts the sample count
      do_reset();
      send(60, 1'b0, last);
      enable = 1'b0;
      sample_valid = 1'b1;
      step(5);
      sample_valid = 1'b0;
      enable = 1'b1;
      step(1);
      c0 = cyc;
      e.cyc = c0 + 128; e.bsel = 1'b1; e.fcnt = 1;
      lq.push_back(e);
      rq.push_back(c0 + 145);
      send(128, 1'b0, last);
      step(25);
      chk("enable_frame_count", int'(frame_count), 1);
      chk_drained("enable");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
